// File: rtl/dpram_be_ctl_if.sv
// Bus bundle for dpram_be_ctl: clear control plus the two byte-enabled access ports.
// The testbench drives the master side; the RAM controller sits on the slave side.
interface dpram_be_ctl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  init_req;
    logic                  init_busy;
    logic                  ce_a;
    logic [ADDR_WIDTH-1:0] address_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  wren_a;
    logic [NB-1:0]         be_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  valid_a;
    logic                  ce_b;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  wren_b;
    logic [NB-1:0]         be_b;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  valid_b;
    logic                  collision;

    modport master (
        output init_req, ce_a, address_a, data_a, wren_a, be_a,
               ce_b, address_b, data_b, wren_b, be_b,
        input  init_busy, q_a, valid_a, q_b, valid_b, collision
    );

    modport slave (
        input  init_req, ce_a, address_a, data_a, wren_a, be_a,
               ce_b, address_b, data_b, wren_b, be_b,
        output init_busy, q_a, valid_a, q_b, valid_b, collision
    );
endinterface

// File: rtl/dpram_be_ctl.sv
// True dual-port byte-enabled RAM with port-A write priority and a hardware clear sweep.
// Define DPRAM_BE_OUTREG_EN to add a second output register stage (read latency 2).
module dpram_be_ctl #(
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   DATA_WIDTH = 16,
    parameter int                   BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                   RDW_MODE   = 0
) (
    input logic           clock,
    input logic           reset,
    dpram_be_ctl_if.slave bus
);
    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  active, clr_we, same_addr;
    logic                  wr_a, wr_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
    logic [DATA_WIDTH-1:0] q_a1_q, q_b1_q;
    logic                  valid_a1_q, valid_b1_q, collision_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.init_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                // Extra MSB flags the terminal count once the last address is written.
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_d[ADDR_WIDTH]) state_d = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign bus.init_busy = (state_q == CLEAR);

    assign active    = (state_q == IDLE) && !reset;
    assign clr_we    = (state_q == CLEAR) && !reset;
    assign same_addr = (bus.address_a == bus.address_b);
    assign wr_a      = active && bus.ce_a && bus.wren_a;
    assign wr_b      = active && bus.ce_b && bus.wren_b;
    assign rd_a      = active && bus.ce_a && !bus.wren_a;
    assign rd_b      = active && bus.ce_b && !bus.wren_b;

    always_ff @(posedge clock) begin
        if (clr_we) mem_q[clr_addr_q[ADDR_WIDTH-1:0]] <= INIT_VALUE;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wr_b && bus.be_b[i] && !(wr_a && same_addr && bus.be_a[i]))
                mem_q[bus.address_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && bus.be_a[i])
                mem_q[bus.address_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // A reading port never writes, so only the other port's lanes can merge in.
    always_comb begin
        rd_word_a = mem_q[bus.address_a];
        rd_word_b = mem_q[bus.address_b];
        if (RDW_MODE != 0 && same_addr) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_b && bus.be_b[i])
                    rd_word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_a && bus.be_a[i])
                    rd_word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a1_q      <= '0;
            q_b1_q      <= '0;
            valid_a1_q  <= 1'b0;
            valid_b1_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            valid_a1_q  <= rd_a;
            valid_b1_q  <= rd_b;
            collision_q <= wr_a && wr_b && same_addr;
            if (rd_a) q_a1_q <= rd_word_a;
            if (rd_b) q_b1_q <= rd_word_b;
        end
    end

    assign bus.collision = collision_q;

`ifdef DPRAM_BE_OUTREG_EN
    logic [DATA_WIDTH-1:0] q_a2_q, q_b2_q;
    logic                  valid_a2_q, valid_b2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a2_q     <= '0;
            q_b2_q     <= '0;
            valid_a2_q <= 1'b0;
            valid_b2_q <= 1'b0;
        end else begin
            valid_a2_q <= valid_a1_q && (state_q == IDLE);
            valid_b2_q <= valid_b1_q && (state_q == IDLE);
            if (valid_a1_q) q_a2_q <= q_a1_q;
            if (valid_b1_q) q_b2_q <= q_b1_q;
        end
    end

    assign bus.q_a     = q_a2_q;
    assign bus.q_b     = q_b2_q;
    assign bus.valid_a = valid_a2_q;
    assign bus.valid_b = valid_b2_q;
`else
    assign bus.q_a     = q_a1_q;
    assign bus.q_b     = q_b1_q;
    assign bus.valid_a = valid_a1_q;
    assign bus.valid_b = valid_b1_q;
`endif
endmodule

// File: doc/dpram_be_ctl.md
Name: dpram_be_ctl

Overview:
Single-clock true dual-port RAM with per-byte write enables and fixed port-A write priority on address collisions. Includes a hardware clear engine that fills the array with INIT_VALUE after reset or on request. Selectable cross-port read-during-write result. Used by the EMU core for shared video/work RAM where both CPU and PPU paths need byte-granular access.

Parameters:
ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
INIT_VALUE, 0, word written to every address by the clear engine
RDW_MODE, 0, cross-port same-address read during write: 0 = old data, 1 = new (merged) data

Ports:
clock  in  1  sole clock, all logic on posedge
reset  in  1  synchronous, active-high
init_req  in  1  pulse; starts a clear sweep when idle
init_busy  out  1  high while the clear sweep runs
ce_a  in  1  port A access enable
address_a  in  ADDR_WIDTH  port A address
data_a  in  DATA_WIDTH  port A write data
wren_a  in  1  port A write (qualified by ce_a)
be_a  in  NB  port A byte enables
q_a  out  DATA_WIDTH  port A read data
valid_a  out  1  q_a updated this cycle
ce_b, address_b, data_b, wren_b, be_b, q_b, valid_b: same as port A, for port B
collision  out  1  1-cycle pulse: both ports wrote the same address

Behaviour:
- Reset values: q_a = q_b = 0, valid_a = valid_b = 0, collision = 0, init_busy = 1. The FSM enters CLEAR with clr_addr = 0.
- FSM states are IDLE and CLEAR.
- In CLEAR:
  - Writes INIT_VALUE to clr_addr each cycle and increments clr_addr.
  - After writing address 2**ADDR_WIDTH-1, moves to IDLE; init_busy drops the following cycle. Total sweep is 2**ADDR_WIDTH cycles.
  - Port A and port B accesses are ignored: no writes, valid stays 0, q holds its value.
  - init_req is ignored.
- In IDLE, init_req=1 moves to CLEAR with clr_addr = 0. init_busy rises the next cycle.
- reset asserted mid-sweep restarts the sweep at address 0.
- Write, per port: ce & wren writes the lanes whose be bit is 1; the other lanes keep their value. A write with be = 0 is a no-op. A write cycle does not update q; valid = 0.
- Read, per port: ce & ~wren, read latency 1 cycle. q takes mem[address] on the next posedge and valid pulses for that cycle. When ce = 0, q holds and valid = 0.
- Collision, when both ports write the same address in the same cycle:
  - Lanes with be_a=1 take data_a.
  - Lanes with be_a=0 and be_b=1 take data_b.
  - collision pulses on the next cycle, even when the be masks do not overlap.
- Different addresses: both writes commit independently.
- Cross-port read during write, when one port reads the address the other port writes:
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the post-write merged word.
- Both ports reading the same address: both get identical data with no conflict.
- Address arithmetic: clr_addr is ADDR_WIDTH+1 bits wide so that the terminal count is detected without wrap aliasing.

Optional Feature:
DPRAM_BE_OUTREG_EN:
- Defined: a second output register stage is added to q_a/q_b and valid_a/valid_b. Read latency becomes 2 cycles, with valid delayed in lockstep. Reset clears both stages, and CLEAR flushes the valid pipeline to 0.
- Undefined: read latency is 1 cycle as described above.

Test Plan:
1. Clear sweep after reset (ADDR_WIDTH=4, INIT_VALUE=16'hA5A5): deassert reset, hold 16 cycles, then read address 0..15 -> every q = 16'hA5A5. init_busy is high for exactly 16 cycles after reset release.
2. Byte merge: write A addr 3 data 16'h1234 be 2'b11, then B addr 3 data 16'hFFEE be 2'b01, then A reads 3 -> q_a = 16'h12EE, valid_a pulse 1 cycle after the read.
3. Collision: same cycle, A writes addr 5 16'hAAAA be 2'b10, B writes addr 5 16'hBBBB be 2'b11 -> mem[5] = 16'hAABB; collision pulses once.
4. Read during write, addr 7 holding 16'h0001, A writes 16'h0002 while B reads 7 -> q_b = 16'h0001 with RDW_MODE=0, q_b = 16'h0002 with RDW_MODE=1.
5. Mid-sweep reset: init_req, then reset after 5 cycles -> sweep restarts at 0, init_busy stays high, and a port A write issued during the sweep is discarded (the address reads INIT_VALUE afterwards).
6. With DPRAM_BE_OUTREG_EN: A reads addr 2 holding 16'h5A5A -> valid_a and q_a = 16'h5A5A appear exactly 2 cycles after the request. Back-to-back reads of 2 and 3 return in order on consecutive cycles.
